// File: rtl/vga_pkg.sv
// Shared definitions for the VGA game blocks: keyboard codes, physics FSM
// states and the level-map colour that counts as solid.
package vga_pkg;

   localparam logic [3:0]  key_NONE = 4'h0;
   localparam logic [3:0]  key_W    = 4'h1;
   localparam logic [3:0]  key_S    = 4'h2;

   localparam logic [11:0] SOLID_RGB_DEFAULT = 12'h000;

   typedef enum logic [2:0] {
      WAIT    = 3'd0,
      PROBE_F = 3'd1,
      WAIT_F  = 3'd2,
      PROBE_C = 3'd3,
      WAIT_C  = 3'd4,
      UPDATE  = 3'd5
   } phys_state_t;

   // A map pixel blocks movement when its colour equals the solid colour.
   function automatic logic is_solid(input logic [11:0] rgb, input logic [11:0] solid);
      return (rgb == solid);
   endfunction

endpackage

// File: rtl/phys_tick_gen.sv
// Free-running physics tick timer: counts 0..TICK_CYCLES-1 and flags the
// terminal count with a registered strobe. Shared by all sprite controllers.
module phys_tick_gen #(
   parameter int TICK_CYCLES = 2000000
) (
   input  logic clk,
   input  logic rst_n,
   output logic o_tc
);

   localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TICK_CYCLES - 1);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_tc;

   // Wrap at the terminal count.
   always_comb begin
      if (r_cnt == C_LAST) begin
         w_cnt_nxt = {CNT_W{1'b0}};
      end else begin
         w_cnt_nxt = r_cnt + CNT_W'(1);
      end
   end

   // Strobe is registered from the next count so it is high exactly while r_cnt == C_LAST.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= {CNT_W{1'b0}};
         r_tc  <= 1'b0;
      end else begin
         r_cnt <= w_cnt_nxt;
         r_tc  <= (w_cnt_nxt == C_LAST);
      end
   end

   assign o_tc = r_tc;

endmodule

// File: rtl/player_physics_y.sv
// Per-tick vertical physics for one sprite: gravity, jump, fast-fall and
// collision probed through the level-map ROM (under the feet, above the head).
module player_physics_y
   import vga_pkg::*;
#(
   parameter int          Y_W         = 10,
   parameter int          Y_MAX       = 448,
   parameter int          PLAYER_H    = 32,
   parameter int          TICK_CYCLES = 2000000,
   parameter int          ROM_LAT     = 1,
   parameter int          VEL_W       = 6,
   parameter int          GRAVITY     = 1,
   parameter int          JUMP_V      = 15,
   parameter int          VMAX        = 8,
   parameter int          COL_W       = 9,
   parameter int          ROW_W       = 7,
   parameter int          PIX_SHIFT   = 2,
   parameter logic [11:0] SOLID_RGB   = SOLID_RGB_DEFAULT
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [3:0]             key,
   input  logic [10:0]            xpos,
   input  logic [11:0]            rgb_pixel,
   output logic [COL_W+ROW_W-1:0] pixel_adr,
   output logic [Y_W-1:0]         player_ypos,
   output logic [VEL_W-1:0]       velocity,
   output logic                   grounded,
   output logic                   tick
);

   localparam int                      ADR_W      = COL_W + ROW_W;
   localparam int                      LAT_W      = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
   localparam logic [LAT_W-1:0]        C_LAT_LAST = LAT_W'(ROM_LAT - 1);
   localparam logic [Y_W-1:0]          C_Y_MAX    = Y_W'(Y_MAX);
   localparam logic [Y_W:0]            C_PLAYER_H = (Y_W+1)'(PLAYER_H);
   localparam logic signed [VEL_W:0]   C_VMAX     = (VEL_W+1)'(VMAX);
   localparam logic signed [VEL_W:0]   C_NEG_JUMP = (VEL_W+1)'(-JUMP_V);
   localparam logic signed [VEL_W:0]   C_G1       = (VEL_W+1)'(GRAVITY);
   localparam logic signed [VEL_W:0]   C_G2       = (VEL_W+1)'(2 * GRAVITY);

   phys_state_t             r_state;
   phys_state_t             w_state_nxt;
   logic [LAT_W-1:0]        r_lat;
   logic                    r_floor_solid;
   logic                    r_ceil_solid;
   logic                    r_jump_req;
   logic [Y_W-1:0]          r_ypos;
   logic [VEL_W-1:0]        r_vel;
   logic                    r_grounded;
   logic [ADR_W-1:0]        r_adr;
   logic                    r_tick;

   logic                    w_tc;
   logic                    w_lat_done;
   logic [ROW_W-1:0]        w_floor_row;
   logic [ROW_W-1:0]        w_ceil_row;
   logic [COL_W-1:0]        w_col;
   logic                    w_on_ground;
   logic signed [VEL_W:0]   w_vel_ext;
   logic signed [VEL_W:0]   w_v_fall;
   logic signed [VEL_W:0]   w_v_fall_sat;
   logic signed [VEL_W:0]   w_v_pre;
   logic [VEL_W-1:0]        w_v;
   logic signed [Y_W:0]     w_y_sum;
   logic [Y_W-1:0]          w_new_y;
   logic                    w_new_grounded;

   phys_tick_gen #(
      .TICK_CYCLES (TICK_CYCLES)
   ) u_tick_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .o_tc  (w_tc)
   );

   assign w_lat_done  = (r_lat == C_LAT_LAST);
   assign w_floor_row = ROW_W'(({1'b0, r_ypos} + C_PLAYER_H) >> PIX_SHIFT);
   assign w_col       = COL_W'(xpos >> PIX_SHIFT);

   // Ceiling probe row; at the top of the screen the probe stays on row 0.
   always_comb begin
      if (r_ypos == {Y_W{1'b0}}) begin
         w_ceil_row = {ROW_W{1'b0}};
      end else begin
         w_ceil_row = ROW_W'((r_ypos - Y_W'(1)) >> PIX_SHIFT);
      end
   end

   // Next-state logic of the probe/update sequencer.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         WAIT:    if (w_tc) w_state_nxt = PROBE_F; else w_state_nxt = WAIT;
         PROBE_F: w_state_nxt = WAIT_F;
         WAIT_F:  if (w_lat_done) w_state_nxt = PROBE_C; else w_state_nxt = WAIT_F;
         PROBE_C: w_state_nxt = WAIT_C;
         WAIT_C:  if (w_lat_done) w_state_nxt = UPDATE; else w_state_nxt = WAIT_C;
         UPDATE:  w_state_nxt = WAIT;
         default: w_state_nxt = WAIT;
      endcase
   end

   // Velocity candidates: falling adds gravity (doubled on fast-fall), capped at terminal speed.
   assign w_vel_ext    = $signed({r_vel[VEL_W-1], r_vel});
   assign w_on_ground  = r_floor_solid || (r_ypos >= C_Y_MAX);
   assign w_v_fall     = (key == key_S) ? (w_vel_ext + C_G2) : (w_vel_ext + C_G1);
   assign w_v_fall_sat = (w_v_fall > C_VMAX) ? C_VMAX : w_v_fall;

   // Jump beats standing still, which beats falling; a solid ceiling then cancels upward motion.
   always_comb begin
      w_v_pre = w_v_fall_sat;
      if (w_on_ground && !r_vel[VEL_W-1] && r_jump_req) begin
         w_v_pre = C_NEG_JUMP;
      end else if (w_on_ground && !r_vel[VEL_W-1]) begin
         w_v_pre = {(VEL_W+1){1'b0}};
      end else begin
         w_v_pre = w_v_fall_sat;
      end
   end

   assign w_v     = (r_ceil_solid && w_v_pre[VEL_W]) ? {VEL_W{1'b0}} : w_v_pre[VEL_W-1:0];
   assign w_y_sum = $signed({1'b0, r_ypos}) + $signed({{(Y_W+1-VEL_W){w_v[VEL_W-1]}}, w_v});

   // Clamp the new position to the visible range.
   always_comb begin
      if (w_y_sum[Y_W]) begin
         w_new_y = {Y_W{1'b0}};
      end else if (w_y_sum[Y_W-1:0] > C_Y_MAX) begin
         w_new_y = C_Y_MAX;
      end else begin
         w_new_y = w_y_sum[Y_W-1:0];
      end
   end

   assign w_new_grounded = (w_new_y == C_Y_MAX) || (w_on_ground && (w_v == {VEL_W{1'b0}}));

   // Sequencer state and ROM latency counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= WAIT;
         r_lat   <= {LAT_W{1'b0}};
      end else begin
         r_state <= w_state_nxt;
         if (((r_state == WAIT_F) || (r_state == WAIT_C)) && !w_lat_done) begin
            r_lat <= r_lat + LAT_W'(1);
         end else begin
            r_lat <= {LAT_W{1'b0}};
         end
      end
   end

   // Probe address is loaded on entry so it is valid throughout the probe state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_adr         <= {ADR_W{1'b0}};
         r_floor_solid <= 1'b0;
         r_ceil_solid  <= 1'b0;
      end else begin
         if (w_state_nxt == PROBE_F) begin
            r_adr <= {w_floor_row, w_col};
         end else if (w_state_nxt == PROBE_C) begin
            r_adr <= {w_ceil_row, w_col};
         end
         if ((r_state == WAIT_F) && w_lat_done) begin
            r_floor_solid <= is_solid(rgb_pixel, SOLID_RGB);
         end
         if ((r_state == WAIT_C) && w_lat_done) begin
            r_ceil_solid <= is_solid(rgb_pixel, SOLID_RGB);
         end
      end
   end

   // Jump latch catches presses shorter than a tick; UPDATE always consumes it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_jump_req <= 1'b0;
      end else if (r_state == UPDATE) begin
         r_jump_req <= 1'b0;
      end else if (key == key_W) begin
         r_jump_req <= 1'b1;
      end
   end

   // Visible physics state only changes on the UPDATE commit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ypos     <= C_Y_MAX;
         r_vel      <= {VEL_W{1'b0}};
         r_grounded <= 1'b1;
         r_tick     <= 1'b0;
      end else begin
         r_tick <= (r_state == UPDATE);
         if (r_state == UPDATE) begin
            r_ypos     <= w_new_y;
            r_vel      <= w_v;
            r_grounded <= w_new_grounded;
         end
      end
   end

   assign pixel_adr   = r_adr;
   assign player_ypos = r_ypos;
   assign velocity    = r_vel;
   assign grounded    = r_grounded;
   assign tick        = r_tick;

endmodule
